// File: rtl/piece_motion_engine_if.sv
// Handshake/bus bundle between the input front end and the piece motion engine.
// The board vectors use bit r*WIDTH+c for row r, column c.
interface piece_motion_engine_if #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned HEIGHT = 20
);
  localparam int unsigned CELLS = WIDTH * HEIGHT;

  logic [CELLS-1:0] settled;
  logic             spawn;
  logic [2:0]       spawn_type;
  logic             ticker;
  logic             rotate;
  logic             rotate_direction;
  logic             left;
  logic             right;
  logic [CELLS-1:0] next_board;
  logic [CELLS-1:0] piece_mask;
  logic             active;
  logic             lock_pulse;
  logic             game_over;

  modport master (
    output settled, spawn, spawn_type, ticker, rotate, rotate_direction, left, right,
    input  next_board, piece_mask, active, lock_pulse, game_over
  );

  modport slave (
    input  settled, spawn, spawn_type, ticker, rotate, rotate_direction, left, right,
    output next_board, piece_mask, active, lock_pulse, game_over
  );
endinterface

// File: rtl/piece_motion_engine.sv
// Falling-tetromino engine: holds the active piece pose, applies gravity, rotation
// and sideways moves when the resulting pose is collision-free, and signals lock.
module piece_motion_engine #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned HEIGHT  = 20,
  parameter int          SPAWN_X = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  piece_motion_engine_if.slave  bus
);
  localparam int unsigned CELLS = WIDTH * HEIGHT;
  localparam int unsigned XW    = $clog2(WIDTH) + 2;
  localparam int unsigned YW    = $clog2(HEIGHT) + 1;
  localparam int unsigned IW    = $clog2(CELLS);
  localparam logic [2:0]  T_I    = 3'd0;
  localparam logic [2:0]  T_O    = 3'd1;
  localparam logic [2:0]  T_NONE = 3'd7;

  typedef enum logic [1:0] {IDLE, ACTIVE, LOCK, OVER} state_t;

  state_t                state;
  logic [2:0]            ptype;
  logic [1:0]            rot;
  logic signed [XW-1:0]  x;
  logic [YW-1:0]         y;
  logic                  rot_pend_q, left_pend_q, right_pend_q, dir_q;
  logic                  rot_prev, left_prev, right_prev;
  logic                  active_q, lock_q, over_q;

  // 4x4 occupancy (bit br*4+bc) of a piece type at a rotation, built by repeated CW turns.
  function automatic logic [15:0] box_mask(input logic [2:0] t, input logic [1:0] r);
    logic [15:0] m;
    logic [15:0] n;
    case (t)
      3'd0:    m = 16'h00F0;
      3'd1:    m = 16'h0066;
      3'd2:    m = 16'h0072;
      3'd3:    m = 16'h0036;
      3'd4:    m = 16'h0063;
      3'd5:    m = 16'h0071;
      3'd6:    m = 16'h0074;
      default: m = 16'h0000;
    endcase
    for (int k = 0; k < 3; k++) begin
      n = m;
      if (k < int'(r) && t != T_O) begin
        n = '0;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            if (t == T_I)
              n[4'(i*4+j)] = m[4'((3-j)*4+i)];
            else if (i < 3 && j < 3)
              n[4'(i*4+j)] = m[4'((2-j)*4+i)];
          end
        end
      end
      m = n;
    end
    return m;
  endfunction

  function automatic logic pose_legal(input logic [15:0] box, input logic signed [XW-1:0] px,
                                      input logic [YW-1:0] py, input logic [CELLS-1:0] board);
    int   row;
    int   col;
    logic ok;
    ok = 1'b1;
    for (int br = 0; br < 4; br++) begin
      for (int bc = 0; bc < 4; bc++) begin
        if (box[4'(br*4+bc)]) begin
          row = int'(py) + br;
          col = int'(px) + bc;
          if (col < 0 || col >= int'(WIDTH) || row >= int'(HEIGHT))
            ok = 1'b0;
          else if (board[IW'(row*int'(WIDTH) + col)])
            ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

  logic rot_rise, left_rise, right_rise;
  logic rot_pend, left_pend, right_pend, eff_dir;

  // A fresh edge counts as pending in the cycle it is seen.
  assign rot_rise   = bus.rotate & ~rot_prev;
  assign left_rise  = bus.left   & ~left_prev;
  assign right_rise = bus.right  & ~right_prev;
  assign rot_pend   = rot_pend_q   | rot_rise;
  assign left_pend  = left_pend_q  | left_rise;
  assign right_pend = right_pend_q | right_rise;
  assign eff_dir    = rot_pend_q ? dir_q : bus.rotate_direction;

  logic [2:0]           cand_type;
  logic [1:0]           cand_rot;
  logic signed [XW-1:0] cand_x;
  logic [YW-1:0]        cand_y;
  logic                 do_tick, do_rot, do_left, do_right;
  logic                 cand_legal;

  // One candidate pose per cycle: spawn pose in IDLE, otherwise the highest-priority action.
  always_comb begin
    cand_type = ptype;
    cand_rot  = rot;
    cand_x    = x;
    cand_y    = y;
    do_tick   = 1'b0;
    do_rot    = 1'b0;
    do_left   = 1'b0;
    do_right  = 1'b0;
    if (state == IDLE) begin
      cand_type = bus.spawn_type;
      cand_rot  = 2'd0;
      cand_x    = XW'(SPAWN_X);
      cand_y    = '0;
    end else if (state == ACTIVE) begin
      if (bus.ticker) begin
        do_tick = 1'b1;
        cand_y  = y + YW'(1);
      end else if (rot_pend) begin
        do_rot   = 1'b1;
        cand_rot = eff_dir ? rot + 2'd1 : rot - 2'd1;
      end else if (left_pend) begin
        do_left = 1'b1;
        cand_x  = x - XW'(1);
      end else if (right_pend) begin
        do_right = 1'b1;
        cand_x   = x + XW'(1);
      end
    end
    cand_legal = pose_legal(box_mask(cand_type, cand_rot), cand_x, cand_y, bus.settled);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptype        <= 3'd0;
      rot          <= 2'd0;
      x            <= '0;
      y            <= '0;
      rot_pend_q   <= 1'b0;
      left_pend_q  <= 1'b0;
      right_pend_q <= 1'b0;
      dir_q        <= 1'b0;
      rot_prev     <= 1'b1;
      left_prev    <= 1'b1;
      right_prev   <= 1'b1;
      active_q     <= 1'b0;
      lock_q       <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      rot_prev   <= bus.rotate;
      left_prev  <= bus.left;
      right_prev <= bus.right;
      lock_q     <= 1'b0;
      case (state)
        IDLE: begin
          rot_pend_q   <= 1'b0;
          left_pend_q  <= 1'b0;
          right_pend_q <= 1'b0;
          if (bus.spawn && bus.spawn_type != T_NONE) begin
            ptype <= bus.spawn_type;
            rot   <= cand_rot;
            x     <= cand_x;
            y     <= cand_y;
            if (cand_legal) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state  <= OVER;
              over_q <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (rot_rise && !rot_pend_q)
            dir_q <= bus.rotate_direction;
          rot_pend_q   <= rot_pend   & ~do_rot;
          left_pend_q  <= left_pend  & ~do_left;
          right_pend_q <= right_pend & ~do_right;
          if (do_tick && !cand_legal) begin
            lock_q       <= 1'b1;
            state        <= LOCK;
            rot_pend_q   <= 1'b0;
            left_pend_q  <= 1'b0;
            right_pend_q <= 1'b0;
          end else if (cand_legal) begin
            rot <= cand_rot;
            x   <= cand_x;
            y   <= cand_y;
          end
        end
        LOCK: begin
          active_q <= 1'b0;
          state    <= IDLE;
        end
        OVER: begin
        end
      endcase
    end
  end

  logic [CELLS-1:0] mask;
  logic [15:0]      cur_box;
  int               mrow;
  int               mcol;

  // Project the registered pose onto the board.
  always_comb begin
    mask    = '0;
    mrow    = 0;
    mcol    = 0;
    cur_box = box_mask(ptype, rot);
    if (active_q) begin
      for (int br = 0; br < 4; br++) begin
        for (int bc = 0; bc < 4; bc++) begin
          if (cur_box[4'(br*4+bc)]) begin
            mrow = int'(y) + br;
            mcol = int'(x) + bc;
            if (mcol >= 0 && mcol < int'(WIDTH) && mrow < int'(HEIGHT))
              mask[IW'(mrow*int'(WIDTH) + mcol)] = 1'b1;
          end
        end
      end
    end
  end

  assign bus.piece_mask = mask;
  assign bus.next_board = bus.settled | mask;
  assign bus.active     = active_q;
  assign bus.lock_pulse = lock_q;
  assign bus.game_over  = over_q;
endmodule

// File: tb/tb_piece_motion_engine.sv
// Bench for piece_motion_engine: a cell-list model of the falling piece checked
// every cycle, plus hand-computed board expectations for the key scenarios.
module tb_piece_motion_engine;
  localparam int W  = 10;
  localparam int H  = 20;
  localparam int N  = W * H;
  localparam int SX = 3;
  localparam int unsigned IW = $clog2(N);

  typedef int quad_t [4];
  typedef enum {M_IDLE, M_FALL, M_LOCK, M_OVER} mstate_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  piece_motion_engine_if #(.WIDTH(W), .HEIGHT(H)) bus();
  piece_motion_engine #(.WIDTH(W), .HEIGHT(H), .SPAWN_X(SX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit run   = 1'b0;

  mstate_t ms;
  quad_t   mr, mc, nr, nc;
  int      mx, my, mtype;
  bit      m_active, m_lock, m_over;
  bit      pr, pl, prt, mdir;
  bit      prev_r, prev_l, prev_rt, er, el, ert;

  task automatic chk_vec(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] cells(input int a, input int b, input int c, input int d);
    logic [N-1:0] v;
    v = '0;
    v[IW'(a)] = 1'b1;
    v[IW'(b)] = 1'b1;
    v[IW'(c)] = 1'b1;
    v[IW'(d)] = 1'b1;
    return v;
  endfunction

  // Rotation-0 cells (row, col) inside the 4x4 box.
  task automatic load_shape(input int t, output quad_t r, output quad_t c);
    case (t)
      0:       begin r = '{1, 1, 1, 1}; c = '{0, 1, 2, 3}; end
      1:       begin r = '{0, 0, 1, 1}; c = '{1, 2, 1, 2}; end
      2:       begin r = '{0, 1, 1, 1}; c = '{1, 0, 1, 2}; end
      3:       begin r = '{0, 0, 1, 1}; c = '{1, 2, 0, 1}; end
      4:       begin r = '{0, 0, 1, 1}; c = '{0, 1, 1, 2}; end
      5:       begin r = '{0, 1, 1, 1}; c = '{0, 0, 1, 2}; end
      default: begin r = '{0, 1, 1, 1}; c = '{2, 0, 1, 2}; end
    endcase
  endtask

  task automatic turn(input quad_t r, input quad_t c, input bit cw, input int t,
                      output quad_t or_, output quad_t oc);
    int k;
    k = (t == 0) ? 3 : 2;
    for (int i = 0; i < 4; i++) begin
      if (t == 1) begin
        or_[i] = r[i]; oc[i] = c[i];
      end else if (cw) begin
        or_[i] = c[i]; oc[i] = k - r[i];
      end else begin
        or_[i] = k - c[i]; oc[i] = r[i];
      end
    end
  endtask

  function automatic bit fits(input quad_t r, input quad_t c, input int ox, input int oy);
    logic [N-1:0] b;
    int row, col;
    b = bus.settled;
    for (int i = 0; i < 4; i++) begin
      row = oy + r[i];
      col = ox + c[i];
      if (col < 0 || col >= W || row < 0 || row >= H) return 1'b0;
      if (b[IW'(row*W + col)]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [N-1:0] exp_mask();
    logic [N-1:0] v;
    v = '0;
    if (m_active)
      for (int i = 0; i < 4; i++) v[IW'((my + mr[i])*W + mx + mc[i])] = 1'b1;
    return v;
  endfunction

  // Reference model of the piece, stepped on each rising clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      ms = M_IDLE; m_active = 0; m_lock = 0; m_over = 0;
      pr = 0; pl = 0; prt = 0; mdir = 0;
      prev_r = 1; prev_l = 1; prev_rt = 1;
      mx = 0; my = 0; mtype = 0;
    end else begin
      er  = bus.rotate && !prev_r;
      el  = bus.left   && !prev_l;
      ert = bus.right  && !prev_rt;
      prev_r = bus.rotate; prev_l = bus.left; prev_rt = bus.right;
      m_lock = 0;
      case (ms)
        M_IDLE: begin
          pr = 0; pl = 0; prt = 0;
          if (bus.spawn && bus.spawn_type != 3'd7) begin
            mtype = int'(bus.spawn_type);
            load_shape(mtype, mr, mc);
            mx = SX; my = 0;
            if (fits(mr, mc, mx, my)) begin ms = M_FALL; m_active = 1; end
            else begin ms = M_OVER; m_over = 1; end
          end
        end
        M_FALL: begin
          if (er && !pr) mdir = bus.rotate_direction;
          pr = pr | er; pl = pl | el; prt = prt | ert;
          if (bus.ticker) begin
            if (fits(mr, mc, mx, my + 1)) my++;
            else begin m_lock = 1; ms = M_LOCK; pr = 0; pl = 0; prt = 0; end
          end else if (pr) begin
            pr = 0;
            turn(mr, mc, mdir, mtype, nr, nc);
            if (fits(nr, nc, mx, my)) begin mr = nr; mc = nc; end
          end else if (pl) begin
            pl = 0;
            if (fits(mr, mc, mx - 1, my)) mx--;
          end else if (prt) begin
            prt = 0;
            if (fits(mr, mc, mx + 1, my)) mx++;
          end
        end
        M_LOCK: begin m_active = 0; ms = M_IDLE; end
        default: begin end
      endcase
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk_vec("piece_mask", bus.piece_mask, exp_mask());
      chk_vec("next_board", bus.next_board, bus.settled | exp_mask());
      chk_bit("active", bus.active, m_active);
      chk_bit("lock_pulse", bus.lock_pulse, m_lock);
      chk_bit("game_over", bus.game_over, m_over);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // 0 ticker, 1 rotate, 2 left, 3 right: assert for one cycle, release for one.
  task automatic pulse(input int which);
    case (which)
      0: bus.ticker = 1'b1;
      1: bus.rotate = 1'b1;
      2: bus.left   = 1'b1;
      default: bus.right = 1'b1;
    endcase
    cyc();
    bus.ticker = 1'b0; bus.rotate = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
    cyc();
  endtask

  task automatic do_spawn(input int t);
    bus.spawn = 1'b1;
    bus.spawn_type = 3'(t);
    cyc();
    bus.spawn = 1'b0;
  endtask

  logic [N-1:0] bd;

  initial begin
    bus.settled = '0; bus.spawn = 0; bus.spawn_type = 3'd0; bus.ticker = 0;
    bus.rotate = 0; bus.rotate_direction = 0; bus.left = 0; bus.right = 0;
    bd = '0;
    bd[7] = 1'b1;
    bus.settled = bd;
    cyc(2);
    run = 1'b1;
    chk_vec("reset_next_board", bus.next_board, bd);
    chk_bit("reset_active", bus.active, 1'b0);
    chk_bit("reset_game_over", bus.game_over, 1'b0);
    rst_n = 1'b1;
    bus.settled = '0;
    cyc();

    // Spawn O and walk it into the left wall.
    do_spawn(1);
    chk_bit("spawn_active", bus.active, 1'b1);
    chk_vec("spawn_o_board", bus.next_board, cells(4, 5, 14, 15));
    repeat (4) pulse(2);
    chk_vec("left_wall", bus.piece_mask, cells(0, 1, 10, 11));
    pulse(2);
    chk_vec("left_wall_blocked", bus.piece_mask, cells(0, 1, 10, 11));

    // Reset mid-fall discards the piece.
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk_vec("reset_discard", bus.piece_mask, '0);

    // Fall to the floor and lock.
    do_spawn(1);
    bus.ticker = 1'b1; cyc(18); bus.ticker = 1'b0;
    chk_vec("floor_rows", bus.piece_mask, cells(184, 185, 194, 195));
    bus.ticker = 1'b1; cyc(); bus.ticker = 1'b0;
    chk_bit("lock_pulse_on", bus.lock_pulse, 1'b1);
    chk_vec("lock_mask_held", bus.piece_mask, cells(184, 185, 194, 195));
    bd = bus.piece_mask;
    cyc();
    chk_bit("lock_pulse_off", bus.lock_pulse, 1'b0);
    chk_bit("lock_inactive", bus.active, 1'b0);

    // Stack a second O on the locked one.
    bus.settled = bd;
    do_spawn(1);
    bus.ticker = 1'b1; cyc(17); bus.ticker = 1'b0;
    chk_vec("stack_mask", bus.piece_mask, cells(164, 165, 174, 175));
    chk_bit("stack_lock", bus.lock_pulse, 1'b1);
    cyc(2);
    bus.settled = '0;

    // T rotation CW then CCW.
    do_spawn(2);
    bus.rotate_direction = 1'b1; pulse(1);
    chk_vec("rot_t_cw", bus.piece_mask, cells(4, 14, 15, 24));
    bus.rotate_direction = 1'b0; pulse(1);
    chk_vec("rot_t_ccw", bus.piece_mask, cells(4, 13, 14, 15));

    // Simultaneous ticker + left, then left + right.
    bus.ticker = 1'b1; bus.left = 1'b1; cyc(); bus.ticker = 1'b0;
    chk_vec("sim_tick_first", bus.piece_mask, cells(14, 23, 24, 25));
    cyc();
    chk_vec("sim_left_second", bus.piece_mask, cells(13, 22, 23, 24));
    bus.left = 1'b0; cyc();
    bus.left = 1'b1; bus.right = 1'b1; cyc();
    chk_vec("lr_left", bus.piece_mask, cells(12, 21, 22, 23));
    cyc();
    chk_vec("lr_net", bus.piece_mask, cells(13, 22, 23, 24));
    bus.left = 1'b0; bus.right = 1'b0; cyc();

    // Full priority chain in one cycle, then drop to lock.
    bus.ticker = 1'b1; bus.rotate = 1'b1; bus.rotate_direction = 1'b1; bus.left = 1'b1;
    cyc(); bus.ticker = 1'b0; cyc(3);
    bus.rotate = 1'b0; bus.left = 1'b0; cyc();
    bus.ticker = 1'b1; cyc(22); bus.ticker = 1'b0; cyc(2);

    do_spawn(7);
    chk_bit("spawn_invalid", bus.active, 1'b0);
    cyc();

    // Every type: rotate, push into the left wall, rotate back, step right, drop.
    for (int t = 0; t < 7; t++) begin
      do_spawn(t);
      bus.rotate_direction = 1'b1; pulse(1);
      repeat (6) pulse(2);
      bus.rotate_direction = 1'b0; pulse(1);
      pulse(3);
      bus.ticker = 1'b1; cyc(22); bus.ticker = 1'b0; cyc(2);
    end

    // Blocked spawn, sticky game over, held button through reset.
    rst_n = 1'b0; bus.left = 1'b1;
    bd = '0; bd[14] = 1'b1; bus.settled = bd;
    cyc(); rst_n = 1'b1;
    do_spawn(1);
    chk_bit("over_set", bus.game_over, 1'b1);
    chk_bit("over_inactive", bus.active, 1'b0);
    bus.settled = '0;
    do_spawn(1);
    chk_bit("over_sticky", bus.game_over, 1'b1);
    chk_bit("over_spawn_ignored", bus.active, 1'b0);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk_bit("over_cleared", bus.game_over, 1'b0);
    do_spawn(1);
    chk_vec("held_left_ignored", bus.piece_mask, cells(4, 5, 14, 15));
    bus.left = 1'b0; cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/piece_motion_engine.md
# piece_motion_engine

Parametrised successor to the combinational next-board stage. Holds the falling tetromino as registered state: type, rotation, x and y. Applies gravity, rotation and left/right moves only when the resulting pose is collision-free, and signals when the piece locks. Sits between the input-debounce/ticker logic and the settled-board/line-clear logic. Its `next_board` drives the display path.

## Interface
- `WIDTH`, 10, board columns
- `HEIGHT`, 20, board rows
- `SPAWN_X`, 3, column of the 4x4 piece box's left edge at spawn
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; synchronous, active-low
- `settled`  in  WIDTH*HEIGHT  locked cells; cell (row r, col c) is bit r*WIDTH+c; row 0 is the top row
- `spawn`  in  1  single-cycle request for a new piece
- `spawn_type`  in  3  piece type: 0=I, 1=O, 2=T, 3=S, 4=Z, 5=J, 6=L; 7 is invalid
- `ticker`  in  1  single-cycle gravity pulse
- `rotate`  in  1  level; a rising edge requests rotation
- `rotate_direction`  in  1  1 = CW, 0 = CCW, sampled on the rotate edge
- `left`, `right`  in  1 each  level; a rising edge requests a one-column move
- `next_board`  out  WIDTH*HEIGHT  `settled | piece_mask`
- `piece_mask`  out  WIDTH*HEIGHT  cells of the active piece; all zero when no piece is active
- `active`  out  1  a piece is falling
- `lock_pulse`  out  1  one cycle; upstream ORs `piece_mask` into `settled`
- `game_over`  out  1  sticky until reset

## Operation
- **Shapes:** 4x4 box; box cell (br, bc) maps to board cell (y+br, x+bc).
  - x is signed, width clog2(WIDTH)+2; y is unsigned.
  - Rotation-0 cells per type:
    - I: row1, cols 0-3
    - O: rows 0-1, cols 1-2
    - T: (0,1) and row1 cols 0-2
    - S: (0,1),(0,2),(1,0),(1,1)
    - Z: (0,0),(0,1),(1,1),(1,2)
    - J: (0,0) and row1 cols 0-2
    - L: (0,2) and row1 cols 0-2
  - CW rotation maps (r,c) to (c,2-r) for T, S, Z, J and L.
  - CW rotation maps (r,c) to (c,3-r) for I.
  - O is rotation-invariant.
  - CCW is the inverse; rot wraps modulo 4.
  - No wall kicks.
- **Legal pose:** every cell satisfies 0≤col<WIDTH and 0≤row<HEIGHT, and its `settled` bit is 0.
- **FSM states:**
  - IDLE
    - Ignores move requests; pending flags are cleared.
    - On `spawn` with a valid type, loads pose (SPAWN_X, 0, rot 0).
    - If that pose is legal, go to ACTIVE; otherwise go to OVER.
    - `spawn` with type 7 is ignored.
  - ACTIVE
    - `spawn` is ignored.
    - At most one action per cycle, in priority order: ticker, then pending rotate, then pending left, then pending right.
    - Gravity with a legal y+1 pose moves down one row.
    - Gravity with an illegal y+1 pose asserts `lock_pulse` for the next cycle. The pose is held during that cycle, then the FSM goes to IDLE.
    - An illegal rotate or move is dropped and its pending flag is cleared.
  - OVER
    - `game_over`=1, `active`=0.
    - All inputs are ignored until reset.
- **Pending flags:**
  - Each rising edge on `rotate`, `left` or `right` sets one flag; `rotate_direction` is latched with the rotate flag.
  - A flag clears when its action is serviced, or on lock.
  - A repeated edge while its flag is set is absorbed.
- **Edge detectors:** prior-sample registers reset to 1, so a button held through reset is ignored until it is released.
- **Reset values:**
  - State IDLE, pose and type 0.
  - `piece_mask`, `active`, `lock_pulse`, `game_over` all 0.
  - `next_board` equals `settled`.
  - Reset mid-fall discards the piece.

## Timing
- Inputs are sampled at posedge clk. A pose change is visible the cycle after its request is serviced.
- Button edge to pose change is 1 cycle when nothing of higher priority is pending; each higher-priority item adds one cycle.
- `spawn` to `active`=1 is 1 cycle.
- `lock_pulse` asserts the cycle after the failing ticker. `active` falls the cycle after `lock_pulse`.
- `piece_mask` and `next_board` are combinational from the registered pose and the current `settled`.
- `settled` must be stable while `active`=1; upstream updates it only on `lock_pulse` or in IDLE.

## Test plan
All scenarios use WIDTH=10, HEIGHT=20, SPAWN_X=3 and an empty board unless stated.
- **Spawn O:** reset, then spawn type 1 -> next cycle `active`=1 and `next_board` has bits 4, 5, 14, 15 set.
- **Left wall:** O spawned, then 5 separate left presses -> after press 4 the cells are cols 0-1 (x=-1); press 5 leaves the pose unchanged.
- **Lock:** O spawned, then 18 ticks -> cells in rows 18-19. Tick 19 -> `lock_pulse` for 1 cycle with the mask unchanged, then `active`=0.
- **Rotate T:** T spawned, rotate CW -> cells (0,4),(1,4),(1,5),(2,4). A following CCW rotate restores (0,4),(1,3),(1,4),(1,5).
- **Simultaneous events:** ticker and left edge in the same cycle -> y+1 on the first cycle, x-1 on the second. Left and right edges together -> net x unchanged after 2 cycles.
- **Game over:** `settled` bit 14 set, spawn O -> `game_over`=1. A later spawn is ignored; `rst_n`=0 for 1 cycle clears `game_over`.
